jtframe_uart_loader: RTL and testbench

//  ROM download initiator: receives a framed ROM image over a UART line and drives the

---
 rtl/jtframe_uart_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_jtframe_uart_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_uart_loader.sv
// UART ROM loader: takes a framed ROM image off uart_rx and replays it as an ioctl write stream.
// Ports: clk/rst_n; uart_rx/uart_tx serial pair (8N1); downloading, ioctl_addr/data/wr download
// stream; load_ok flags the last frame as good. Frame: A5, LEN[23:0] MSB first, data, CSUM.
module jtframe_uart_loader #(
  parameter int CLKDIV  = 347,
  parameter int TIMEOUT = 4000000,
  parameter int AW      = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_rx,
  output logic          uart_tx,
  output logic          downloading,
  output logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_data,
  output logic          ioctl_wr,
  output logic          load_ok
);

  localparam int CW = $clog2(CLKDIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SOF = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // ---------------- receiver ----------------
  logic          rx_m_q, rx_s_q, rx_p_q;
  logic          rx_busy_q, rx_vld_q, rx_err_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;   // 0 = start bit, 1..8 = data, 9 = stop
  logic [7:0]    rx_sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_p_q    <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_m_q   <= uart_rx;
      rx_s_q   <= rx_m_q;
      rx_p_q   <= rx_s_q;
      rx_vld_q <= 1'b0;
      rx_err_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_p_q && !rx_s_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= CW'(CLKDIV / 2 - 1);   // first sample lands mid start bit
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end else begin
        rx_cnt_q <= CW'(CLKDIV - 1);
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          if (rx_s_q) rx_busy_q <= 1'b0;      // line back high: glitch, not a start bit
        end else if (rx_bit_q <= 4'd8) begin
          rx_sh_q <= {rx_s_q, rx_sh_q[7:1]};
        end else begin
          rx_busy_q <= 1'b0;
          if (rx_s_q) rx_vld_q <= 1'b1;
          else        rx_err_q <= 1'b1;
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  logic          tx_busy_q, tx_start_q, tx_start_d;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [9:0]    tx_sh_q;    // idles all-ones so uart_tx rests high
  logic [7:0]    reply_q, reply_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else if (tx_start_q) begin
      tx_busy_q <= 1'b1;
      tx_cnt_q  <= CW'(CLKDIV - 1);
      tx_bit_q  <= '0;
      tx_sh_q   <= {1'b1, reply_q, 1'b0};
    end else if (tx_busy_q) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end else begin
        tx_cnt_q <= CW'(CLKDIV - 1);
        tx_bit_q <= tx_bit_q + 4'd1;
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      end
    end
  end

  assign uart_tx = tx_sh_q[0];

  // ---------------- frame FSM ----------------
  typedef enum logic [2:0] {S_IDLE, S_L2, S_L1, S_L0, S_DATA, S_CSUM, S_REPLY} state_t;

  state_t        state_q, state_d;
  logic [23:0]   len_q, len_d, new_len;
  logic [AW-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [7:0]    sum_q, sum_d, data_q, data_d;
  logic [TW-1:0] to_q, to_d;
  logic          dl_q, dl_d, wr_q, wr_d, ok_q, ok_d;
  logic          in_frame, timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      sum_q      <= '0;
      data_q     <= '0;
      to_q       <= '0;
      dl_q       <= 1'b0;
      wr_q       <= 1'b0;
      ok_q       <= 1'b0;
      reply_q    <= NAK;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      data_q     <= data_d;
      to_q       <= to_d;
      dl_q       <= dl_d;
      wr_q       <= wr_d;
      ok_q       <= ok_d;
      reply_q    <= reply_d;
      tx_start_q <= tx_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    sum_d      = sum_q;
    data_d     = data_q;
    dl_d       = dl_q;
    wr_d       = 1'b0;
    ok_d       = ok_q;
    reply_d    = reply_q;
    tx_start_d = 1'b0;
    new_len    = {len_q[15:0], rx_sh_q};
    in_frame   = (state_q == S_L2) || (state_q == S_L1) || (state_q == S_L0) ||
                 (state_q == S_DATA) || (state_q == S_CSUM);
    // Idle-gap counter only runs inside a frame and restarts on every received byte.
    to_d       = (rx_vld_q || !in_frame) ? '0 : to_q + 1'b1;
    timed_out  = in_frame && !rx_vld_q && (to_q == TW'(TIMEOUT - 1));

    case (state_q)
      S_IDLE: if (rx_vld_q && rx_sh_q == SOF) begin
        ok_d    = 1'b0;
        len_d   = '0;
        state_d = S_L2;
      end
      S_L2, S_L1: if (rx_vld_q) begin
        len_d   = new_len;
        state_d = (state_q == S_L2) ? S_L1 : S_L0;
      end
      S_L0: if (rx_vld_q) begin
        len_d = new_len;
        if (new_len == '0 || 33'(new_len) > (33'd1 << AW)) begin
          reply_d    = NAK;
          tx_start_d = 1'b1;
          state_d    = S_REPLY;
        end else begin
          dl_d    = 1'b1;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (rx_vld_q) begin
        wr_d   = 1'b1;
        data_d = rx_sh_q;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 1'b1;
        sum_d  = sum_q + rx_sh_q;
        if (33'(cnt_q) + 33'd1 == 33'(len_q)) state_d = S_CSUM;
      end
      S_CSUM: if (rx_vld_q) begin
        dl_d       = 1'b0;
        ok_d       = (rx_sh_q == sum_q);
        reply_d    = (rx_sh_q == sum_q) ? ACK : NAK;
        tx_start_d = 1'b1;
        state_d    = S_REPLY;
      end
      S_REPLY: if (!tx_start_q && !tx_busy_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Framing error or stalled line inside a frame abandons it with a NAK.
    if (in_frame && (rx_err_q || timed_out)) begin
      dl_d       = 1'b0;
      wr_d       = 1'b0;
      reply_d    = NAK;
      tx_start_d = 1'b1;
      state_d    = S_REPLY;
    end
  end

  assign downloading = dl_q;
  assign ioctl_addr  = addr_q;
  assign ioctl_data  = data_q;
  assign ioctl_wr    = wr_q;
  assign load_ok     = ok_q;

endmodule

// File: tb/tb_jtframe_uart_loader.sv
module tb_jtframe_uart_loader;
  localparam int CLKDIV = 8;
  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx, downloading, ioctl_wr, load_ok;
  logic [AW-1:0] ioctl_addr;
  logic [7:0] ioctl_data;

  always #5 clk = ~clk;

  jtframe_uart_loader #(.CLKDIV(CLKDIV), .TIMEOUT(2000), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .downloading(downloading), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wr(ioctl_wr), .load_ok(load_ok)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // write stream and downloading monitors
  logic [AW-1:0] wa[$];
  logic [7:0]    wd[$];
  bit            dl_seen = 1'b0;

  always @(negedge clk) begin
    if (ioctl_wr === 1'b1) begin
      wa.push_back(ioctl_addr);
      wd.push_back(ioctl_data);
    end
    if (downloading === 1'b1) dl_seen = 1'b1;
  end

  // serial decoder for replies
  int         tx_n = 0;
  logic [7:0] tx_last = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        logic [7:0] b;
        repeat (CLKDIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKDIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CLKDIV) @(negedge clk);
        tx_last = b;
        tx_n++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    idle(CLKDIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CLKDIV);
    end
    uart_rx = stop_bit;
    idle(CLKDIV);
    uart_rx = 1'b1;
    idle(2);
  endtask

  logic [7:0] fr[$];

  task automatic send_fr();
    foreach (fr[i]) send_byte(fr[i], 1'b1);
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    dl_seen = 1'b0;
  endtask

  task automatic expect_reply(input string tag, input int target, input logic [7:0] b);
    for (int i = 0; i < 400 && tx_n < target; i++) @(negedge clk);
    chk({tag, "_reply_cnt"}, tx_n, target);
    chk({tag, "_reply_byte"}, tx_last, b);
  endtask

  task automatic glitch();
    @(negedge clk);
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(60);
  endtask

  int t;
  logic [7:0] exp_d[3];

  initial begin
    #1 rst_n = 1'b0;
    idle(3);
    chk("rst_tx", uart_tx, 1);
    chk("rst_dl", downloading, 0);
    chk("rst_wr", ioctl_wr, 0);
    chk("rst_addr", ioctl_addr, 0);
    chk("rst_data", ioctl_data, 0);
    chk("rst_ok", load_ok, 0);
    rst_n = 1'b1;
    idle(5);

    // good frame
    clr(); t = tx_n + 1;
    fr = {8'hA5, 8'h00, 8'h00, 8'h03}; send_fr();
    chk("t1_dl_after_len", downloading, 1);
    fr = {8'h11, 8'h22, 8'h33}; send_fr();
    chk("t1_dl_before_csum", downloading, 1);
    send_byte(8'h66, 1'b1);
    chk("t1_dl_after_csum", downloading, 0);
    expect_reply("t1", t, 8'h06);
    chk("t1_ok", load_ok, 1);
    chk("t1_nwr", wa.size(), 3);
    exp_d = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk("t1_addr", wa[i], i);
      chk("t1_data", wd[i], exp_d[i]);
    end

    // bad checksum
    clr(); t = tx_n + 1;
    send_byte(8'hA5, 1'b1);
    chk("t2_ok_cleared", load_ok, 0);
    fr = {8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67}; send_fr();
    expect_reply("t2", t, 8'h15);
    chk("t2_ok", load_ok, 0);
    chk("t2_nwr", wa.size(), 3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk("t2_addr", wa[i], i);
      chk("t2_data", wd[i], exp_d[i]);
    end

    // garbage then zero length
    clr(); t = tx_n + 1;
    fr = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00}; send_fr();
    expect_reply("t3", t, 8'h15);
    chk("t3_nwr", wa.size(), 0);
    chk("t3_dl_seen", dl_seen, 0);

    // short frame, line stalls
    clr(); t = tx_n + 1;
    fr = {8'hA5, 8'h00, 8'h00, 8'h04, 8'hAA, 8'hBB}; send_fr();
    idle(2500);
    expect_reply("t4", t, 8'h15);
    chk("t4_dl", downloading, 0);
    chk("t4_nwr", wa.size(), 2);
    chk("t4_last_data", ioctl_data, 8'hBB);
    clr(); t = tx_n + 1;
    fr = {8'hA5, 8'h00, 8'h00, 8'h01, 8'h5A, 8'h5A}; send_fr();
    expect_reply("t4b", t, 8'h06);
    chk("t4b_nwr", wa.size(), 1);
    chk("t4b_ok", load_ok, 1);

    // framing error on a data byte
    clr(); t = tx_n + 1;
    fr = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h11}; send_fr();
    send_byte(8'h22, 1'b0);
    expect_reply("t5", t, 8'h15);
    chk("t5_nwr", wa.size(), 1);
    chk("t5_dl", downloading, 0);

    // short glitches in idle and between header bytes
    clr(); t = tx_n + 1;
    glitch();
    send_byte(8'hA5, 1'b1);
    glitch();
    fr = {8'h00, 8'h00, 8'h01, 8'h5A, 8'h5A}; send_fr();
    expect_reply("t5b", t, 8'h06);
    chk("t5b_nwr", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("t5b_addr", wa[0], 0);
      chk("t5b_data", wd[0], 8'h5A);
    end

    // reset in the middle of the data phase
    clr();
    fr = {8'hA5, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22}; send_fr();
    chk("t6_dl_pre", downloading, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_dl", downloading, 0);
    chk("t6_wr", ioctl_wr, 0);
    chk("t6_addr", ioctl_addr, 0);
    chk("t6_data", ioctl_data, 0);
    chk("t6_ok", load_ok, 0);
    chk("t6_tx", uart_tx, 1);
    idle(3);
    rst_n = 1'b1;
    idle(5);
    clr(); t = tx_n + 1;
    fr = {8'hA5, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31}; send_fr();
    expect_reply("t6b", t, 8'h06);
    chk("t6b_nwr", wa.size(), 3);
    exp_d = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk("t6b_addr", wa[i], i);
      chk("t6b_data", wd[i], exp_d[i]);
    end
    chk("t6b_ok", load_ok, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
